// File: rtl/swap_checker.sv
// Checks a two-stage register pair against a nonblocking shift reference over a fixed run.
// Optional first-error capture is enabled by defining SWAP_CHECKER_FIRST_ERR_EN.
module swap_checker #(
    parameter int unsigned NUM_CHECKS = 16,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             a_o,
    input  logic             b_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
`ifdef SWAP_CHECKER_FIRST_ERR_EN
    ,
    output logic [7:0]       first_err_idx,
    output logic [3:0]       first_err_val
`endif
);

    typedef enum logic [1:0] {StIdle, StArm, StCheck, StDone} state_e;

    localparam logic [7:0] LastCheck = 8'(NUM_CHECKS - 1);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;
    logic             exp_a_q, exp_b_q;
    logic             mismatch;

    // b_i drives the pair under check only; the reference model is fed from a_i.
    logic unused_b_i;
    assign unused_b_i = b_i;

`ifdef SWAP_CHECKER_FIRST_ERR_EN
    logic [7:0] fe_idx_q, fe_idx_d;
    logic [3:0] fe_val_q, fe_val_d;
`endif

    assign mismatch = ({a_o, b_o} != {exp_a_q, exp_b_q});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pass_d  = pass_q;
`ifdef SWAP_CHECKER_FIRST_ERR_EN
        fe_idx_d = fe_idx_q;
        fe_val_d = fe_val_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StArm;
                    cnt_d   = 8'd0;
                    err_d   = '0;
                    pass_d  = 1'b0;
`ifdef SWAP_CHECKER_FIRST_ERR_EN
                    fe_idx_d = 8'hFF;
                    fe_val_d = 4'h0;
`endif
                end
            end
            StArm: begin
                if (cnt_q == 8'd1) begin
                    state_d = StCheck;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    if (err_q != '1) err_d = err_q + ERR_W'(1);
`ifdef SWAP_CHECKER_FIRST_ERR_EN
                    if (err_q == '0) begin
                        fe_idx_d = cnt_q;
                        fe_val_d = {a_o, b_o, exp_a_q, exp_b_q};
                    end
`endif
                end
                if (cnt_q == LastCheck) begin
                    state_d = StDone;
                    cnt_d   = 8'd0;
                    // Include the final compare so pass is valid alongside done.
                    pass_d  = (err_q == '0) && !mismatch;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            exp_a_q <= 1'b0;
            exp_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            exp_a_q <= a_i;
            exp_b_q <= exp_a_q;
        end
    end

`ifdef SWAP_CHECKER_FIRST_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fe_idx_q <= 8'hFF;
            fe_val_q <= 4'h0;
        end else begin
            fe_idx_q <= fe_idx_d;
            fe_val_q <= fe_val_d;
        end
    end

    assign first_err_idx = fe_idx_q;
    assign first_err_val = fe_val_q;
`endif

    assign busy    = (state_q == StArm) || (state_q == StCheck);
    assign done    = (state_q == StDone);
    assign pass    = pass_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_swap_checker.sv
// Scoreboard bench for swap_checker: a default-width and a 3-bit-counter instance share stimulus.
module tb_swap_checker;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0, a_i = 1'b0, b_i = 1'b0, a_o = 1'b0, b_o = 1'b0;
    logic busy, done, pass, busy3, done3, pass3;
    logic [7:0] err_cnt;
    logic [2:0] err_cnt3;
`ifdef SWAP_CHECKER_FIRST_ERR_EN
    logic [7:0] fidx, fidx3;
    logic [3:0] fval, fval3;
`endif

    swap_checker #(.NUM_CHECKS(N), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_i(a_i), .b_i(b_i), .a_o(a_o), .b_o(b_o),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
`ifdef SWAP_CHECKER_FIRST_ERR_EN
        , .first_err_idx(fidx), .first_err_val(fval)
`endif
    );

    swap_checker #(.NUM_CHECKS(N), .ERR_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_i(a_i), .b_i(b_i), .a_o(a_o), .b_o(b_o),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err_cnt3)
`ifdef SWAP_CHECKER_FIRST_ERR_EN
        , .first_err_idx(fidx3), .first_err_val(fval3)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int m;
        int done_cyc;
        int fidx;
        int fval;
    } exp_t;
    exp_t sbq[$];

    bit prev1 = 1'b0, prev2 = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle's inputs, let the edge sample them, then settle.
    task automatic step(input bit ai, input bit ao, input bit bo, input bit st);
        a_i = ai; a_o = ao; b_o = bo; b_i = ao; start = st;
        @(posedge clk);
        #1;
        prev2 = prev1;
        prev1 = ai;
    endtask

    task automatic idle_step();
        step(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'b0);
    endtask

    // mode: 0 correct pair/toggle, 1 blocking pair/toggle, 2 random a_i with sparse faults,
    //       3 correct pair/toggle with b_o flipped at check 3, 4 fully random outputs
    task automatic run(input int mode, input bit hold, input int st_at, input int rst_at);
        bit full[N + 6];
        bit ao[N + 4];
        bit bo[N + 4];
        bit ea, eb;
        logic [3:0] v;
        exp_t e;
        full[0] = prev2;
        full[1] = prev1;
        for (int c = 0; c < N + 4; c++)
            full[c + 2] = (mode == 2 || mode == 4) ? 1'($urandom % 2) : ~full[c + 1];
        e.m = 0; e.fidx = 255; e.fval = 0;
        for (int c = 0; c < N + 4; c++) begin
            ea = full[c + 1];
            eb = full[c];
            case (mode)
                1: begin ao[c] = ea; bo[c] = ea; end
                2: begin
                    ao[c] = ea ^ ($urandom % 6 == 0);
                    bo[c] = eb ^ ($urandom % 6 == 0);
                end
                3: begin ao[c] = ea; bo[c] = eb ^ (c == 6); end
                4: begin ao[c] = 1'($urandom % 2); bo[c] = 1'($urandom % 2); end
                default: begin ao[c] = ea; bo[c] = eb; end
            endcase
            if (c >= 3 && c < N + 3 && {ao[c], bo[c]} != {ea, eb}) begin
                if (e.m == 0) begin
                    e.fidx = c - 3;
                    v = {ao[c], bo[c], ea, eb};
                    e.fval = int'(v);
                end
                e.m++;
            end
        end
        e.done_cyc = cyc + 3 + N;
        sbq.push_back(e);
        for (int c = 0; c < N + 4; c++) begin
            if (c == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_err_cnt", err_cnt, 0);
                check("rst_err_cnt3", err_cnt3, 0);
                check("rst_pass", pass, 0);
                sbq.delete();
                a_i = 1'b0; start = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                prev1 = 1'b0; prev2 = 1'b0;
                return;
            end
            step(full[c + 2], ao[c], bo[c], (c == 0) || (c == st_at) || hold);
            if (c == 0) check("busy_in_arm", busy, 1);
            if (c == N + 2) check("busy_in_done", busy, 0);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse, then checks the hold in IDLE.
    initial begin
        exp_t e;
        bit hold_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_chk = 1'b0;
            end else if (done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("done_latency", cyc, e.done_cyc);
                    check("err_cnt", err_cnt, (e.m > 255) ? 255 : e.m);
                    check("pass", pass, (e.m == 0) ? 1 : 0);
                    check("done3", done3, 1);
                    check("err_cnt3_sat", err_cnt3, (e.m > 7) ? 7 : e.m);
                    check("pass3", pass3, (e.m == 0) ? 1 : 0);
`ifdef SWAP_CHECKER_FIRST_ERR_EN
                    check("first_err_idx", fidx, e.fidx);
                    check("first_err_val", fval, e.fval);
`endif
                    hold_chk = 1'b1;
                end
            end else if (hold_chk) begin
                check("err_cnt_hold", err_cnt, (e.m > 255) ? 255 : e.m);
                check("pass_hold", pass, (e.m == 0) ? 1 : 0);
                hold_chk = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_pass", pass, 0);
        check("reset_err_cnt", err_cnt, 0);
        check("reset_err_cnt3", err_cnt3, 0);
`ifdef SWAP_CHECKER_FIRST_ERR_EN
        check("reset_first_err_idx", fidx, 255);
        check("reset_first_err_val", fval, 0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        prev1 = 1'b0; prev2 = 1'b0;
        repeat (2) idle_step();

        run(0, 1'b0, -1, -1);           // correct pair
        repeat (3) idle_step();
        run(1, 1'b0, -1, -1);           // blocking pair: all mismatch, 3-bit saturates
        idle_step();
        run(3, 1'b0, -1, -1);           // single fault at check 3
        idle_step();
        run(1, 1'b0, 8, -1);            // extra start at check 5 ignored
        idle_step();
        run(2, 1'b1, -1, -1);           // start held high through done
        run(0, 1'b0, -1, -1);           // back-to-back run from held start
        idle_step();
        run(4, 1'b0, -1, 11);           // reset at check 8
        repeat (2) idle_step();
        run(0, 1'b0, -1, -1);
        for (int i = 0; i < 8; i++) begin
            run(($urandom % 2 == 0) ? 2 : 4, 1'b0, -1, -1);
            repeat ($urandom_range(0, 3)) idle_step();
        end
        repeat (4) idle_step();
        check("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
